// File: rtl/cc_speedtick_gen_pkg.sv
// -----------------------------------------------------------------------------
// cc_speedtick_gen_pkg
// Shared definitions for the speed-tick generator:
//   - state_t      : run-control state encoding (STOP / RUN / PAUSE)
//   - spd_tc()     : terminal count for a level, (2^width - 1) >> level
//   - sat_level()  : clamps a requested level to the highest legal level
// -----------------------------------------------------------------------------
package cc_speedtick_gen_pkg;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // Widest counter the terminal-count helper supports.
    localparam int unsigned TC_MAX_W = 32;

    // All-ones of 'width' bits, shifted right once per speed level, so each
    // level halves the tick period.
    function automatic logic [TC_MAX_W-1:0] spd_tc(input int unsigned width,
                                                   input int unsigned level);
        logic [TC_MAX_W:0] one;
        logic [TC_MAX_W:0] ones;
        one  = {{TC_MAX_W{1'b0}}, 1'b1};
        ones = (one << width) - one;
        return ones[TC_MAX_W-1:0] >> level;
    endfunction

    // Saturate a requested level to levels-1.
    function automatic int unsigned sat_level(input int unsigned req,
                                              input int unsigned levels);
        return (req >= levels) ? (levels - 1) : req;
    endfunction

endpackage

// File: rtl/cc_speedtick_tc_rom.sv
// -----------------------------------------------------------------------------
// cc_speedtick_tc_rom
// Combinational level -> terminal-count lookup.
// Ports:
//   level  in   LEVELWIDTH  active speed level
//   tc     out  DATAWIDTH   terminal count for that level
// Levels at or above LEVELS (never reached in normal use) map to the top
// level's terminal count.
// -----------------------------------------------------------------------------
module cc_speedtick_tc_rom
    import cc_speedtick_gen_pkg::*;
#(
    parameter int DATAWIDTH  = 25,
    parameter int LEVELS     = 4,
    parameter int LEVELWIDTH = 2
) (
    input  logic [LEVELWIDTH-1:0] level,
    output logic [DATAWIDTH-1:0]  tc
);

    always_comb begin
        tc = DATAWIDTH'(spd_tc(DATAWIDTH, LEVELS - 1));
        for (int l = 0; l < LEVELS; l++) begin
            if (level == LEVELWIDTH'(l)) begin
                tc = DATAWIDTH'(spd_tc(DATAWIDTH, l));
            end
        end
    end

endmodule

// File: rtl/cc_speedtick_gen.sv
// -----------------------------------------------------------------------------
// cc_speedtick_gen
// Speed-tick generator: a free-running counter is compared against a
// level-dependent terminal count and a one-cycle active-low tick is emitted
// each period. The level can be loaded at runtime and can auto-accelerate
// after TICKS_PER_LEVEL ticks.
// Ports:
//   CC_SPEEDTICK_CLOCK_50      in   1           clock, rising edge
//   CC_SPEEDTICK_RESET_InLow   in   1           async reset, active low
//   CC_SPEEDTICK_enable_In     in   1           1 = count, 0 = pause
//   CC_SPEEDTICK_clear_In      in   1           sync restart, level kept
//   CC_SPEEDTICK_autoMode_In   in   1           auto-accelerate enable
//   CC_SPEEDTICK_levelLoad_In  in   1           strobe capturing level_InBUS
//   CC_SPEEDTICK_level_InBUS   in   LEVELWIDTH  requested level
//   CC_SPEEDTICK_T0_OutLow     out  1           registered tick, low 1 cycle
//   CC_SPEEDTICK_level_OutBUS  out  LEVELWIDTH  active level
//   CC_SPEEDTICK_maxLevel_Out  out  1           active level is LEVELS-1
// -----------------------------------------------------------------------------
module cc_speedtick_gen
    import cc_speedtick_gen_pkg::*;
#(
    parameter int DATAWIDTH       = 25,
    parameter int LEVELS          = 4,
    parameter int LEVELWIDTH      = 2,
    parameter int TICKS_PER_LEVEL = 16
) (
    input  logic                  CC_SPEEDTICK_CLOCK_50,
    input  logic                  CC_SPEEDTICK_RESET_InLow,
    input  logic                  CC_SPEEDTICK_enable_In,
    input  logic                  CC_SPEEDTICK_clear_In,
    input  logic                  CC_SPEEDTICK_autoMode_In,
    input  logic                  CC_SPEEDTICK_levelLoad_In,
    input  logic [LEVELWIDTH-1:0] CC_SPEEDTICK_level_InBUS,
    output logic                  CC_SPEEDTICK_T0_OutLow,
    output logic [LEVELWIDTH-1:0] CC_SPEEDTICK_level_OutBUS,
    output logic                  CC_SPEEDTICK_maxLevel_Out
);

    localparam int TCW = $clog2(TICKS_PER_LEVEL + 1);
    localparam logic [LEVELWIDTH-1:0] TOP_LEVEL = LEVELWIDTH'(LEVELS - 1);
    localparam logic [TCW-1:0] TCNT_LAST = TCW'(TICKS_PER_LEVEL - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [DATAWIDTH-1:0]    count;
    logic [DATAWIDTH-1:0]    tc;
    logic [TCW-1:0]          tick_count;
    logic [LEVELWIDTH-1:0]   level;
    logic [LEVELWIDTH-1:0]   pend_level;
    logic                    pend_vld;
    logic                    t0_n;
    logic                    tick;
    logic                    apply_stop;
    logic                    counting;

    cc_speedtick_tc_rom #(
        .DATAWIDTH  (DATAWIDTH),
        .LEVELS     (LEVELS),
        .LEVELWIDTH (LEVELWIDTH)
    ) u_tc_rom (
        .level (level),
        .tc    (tc)
    );

    // State register
    always_ff @(posedge CC_SPEEDTICK_CLOCK_50 or negedge CC_SPEEDTICK_RESET_InLow) begin
        if (!CC_SPEEDTICK_RESET_InLow) begin
            state <= ST_STOP;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-cycle events. clear overrides everything, so every
    // event below is masked by it.
    always_comb begin
        state_nxt  = state;
        counting   = 1'b0;
        tick       = 1'b0;
        apply_stop = 1'b0;
        if (CC_SPEEDTICK_clear_In) begin
            state_nxt = ST_STOP;
        end else begin
            case (state)
                ST_STOP: begin
                    apply_stop = pend_vld;
                    if (CC_SPEEDTICK_enable_In) state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    if (CC_SPEEDTICK_enable_In) begin
                        counting = 1'b1;
                        tick     = (count == tc);
                    end else begin
                        state_nxt = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (CC_SPEEDTICK_enable_In) state_nxt = ST_RUN;
                end
                default: state_nxt = ST_STOP;
            endcase
        end
    end

    // Period counter: only advances in RUN with enable high; the edge that
    // enters RUN does not advance it, so a resume picks up exactly where the
    // pause left off.
    always_ff @(posedge CC_SPEEDTICK_CLOCK_50 or negedge CC_SPEEDTICK_RESET_InLow) begin
        if (!CC_SPEEDTICK_RESET_InLow) begin
            count <= '0;
        end else if (CC_SPEEDTICK_clear_In) begin
            count <= '0;
        end else if (counting) begin
            count <= tick ? '0 : count + DATAWIDTH'(1);
        end
    end

    // Level and auto-acceleration tick counter. A pending load wins over
    // auto-increment; the level only ever moves on a tick or while stopped.
    always_ff @(posedge CC_SPEEDTICK_CLOCK_50 or negedge CC_SPEEDTICK_RESET_InLow) begin
        if (!CC_SPEEDTICK_RESET_InLow) begin
            level      <= '0;
            tick_count <= '0;
        end else if (CC_SPEEDTICK_clear_In) begin
            tick_count <= '0;
        end else if (apply_stop || (tick && pend_vld)) begin
            level      <= pend_level;
            tick_count <= '0;
        end else if (tick && CC_SPEEDTICK_autoMode_In) begin
            if (tick_count == TCNT_LAST) begin
                tick_count <= '0;
                if (level != TOP_LEVEL) level <= level + LEVELWIDTH'(1);
            end else begin
                tick_count <= tick_count + TCW'(1);
            end
        end
    end

    // Pending-load flag. A strobe in the same cycle as an application is a new
    // request, so capture takes priority over consumption.
    always_ff @(posedge CC_SPEEDTICK_CLOCK_50 or negedge CC_SPEEDTICK_RESET_InLow) begin
        if (!CC_SPEEDTICK_RESET_InLow) begin
            pend_vld <= 1'b0;
        end else if (CC_SPEEDTICK_levelLoad_In) begin
            pend_vld <= 1'b1;
        end else if (apply_stop || (tick && pend_vld)) begin
            pend_vld <= 1'b0;
        end
    end

    // Pending level value; only meaningful while pend_vld is set.
    always_ff @(posedge CC_SPEEDTICK_CLOCK_50) begin
        if (CC_SPEEDTICK_levelLoad_In) begin
            pend_level <= LEVELWIDTH'(sat_level(32'(CC_SPEEDTICK_level_InBUS), LEVELS));
        end
    end

    // Registered tick output: low for the single cycle after a tick edge.
    always_ff @(posedge CC_SPEEDTICK_CLOCK_50 or negedge CC_SPEEDTICK_RESET_InLow) begin
        if (!CC_SPEEDTICK_RESET_InLow) begin
            t0_n <= 1'b1;
        end else begin
            t0_n <= ~tick;
        end
    end

    assign CC_SPEEDTICK_T0_OutLow    = t0_n;
    assign CC_SPEEDTICK_level_OutBUS = level;
    assign CC_SPEEDTICK_maxLevel_Out = (level == TOP_LEVEL);

endmodule

// File: doc/cc_speedtick_gen.md
Name: cc_speedtick_gen

Overview:
Parametrised speed-tick generator. It is the successor of the fixed all-ones speed comparator. A free-running counter is compared against a level-dependent terminal count, and the block emits a one-cycle active-low T0 tick. Speed level is loadable at runtime and can auto-accelerate after a programmable number of ticks. The block feeds game/animation state machines that advance one step per T0 tick.

Parameters:
DATAWIDTH, 25, counter width; level-0 terminal count is 2^DATAWIDTH-1 (all ones).
LEVELS, 4, number of speed levels; must be <= DATAWIDTH.
LEVELWIDTH, 2, width of level buses; must satisfy 2^LEVELWIDTH >= LEVELS.
TICKS_PER_LEVEL, 16, ticks at one level before auto-increment; must be >= 1.

Ports:
CC_SPEEDTICK_CLOCK_50  in  1  system clock, rising edge.
CC_SPEEDTICK_RESET_InLow  in  1  asynchronous, active-low reset.
CC_SPEEDTICK_enable_In  in  1  1 = count; 0 = pause, holding all state.
CC_SPEEDTICK_clear_In  in  1  synchronous restart of counters; level is kept.
CC_SPEEDTICK_autoMode_In  in  1  1 = auto-accelerate enabled.
CC_SPEEDTICK_levelLoad_In  in  1  one-cycle strobe; captures level_InBUS.
CC_SPEEDTICK_level_InBUS  in  LEVELWIDTH  requested level.
CC_SPEEDTICK_T0_OutLow  out  1  registered tick, low for exactly 1 cycle.
CC_SPEEDTICK_level_OutBUS  out  LEVELWIDTH  active level.
CC_SPEEDTICK_maxLevel_Out  out  1  high when active level = LEVELS-1.

Behaviour:
- Reset is asynchronous and active-low.
  - On reset: count=0, tickCount=0, level=0, pending invalid, state=STOP.
  - Outputs in reset: T0_OutLow=1, level_OutBUS=0, maxLevel_Out=(LEVELS==1).
- Terminal count: TC(L) = (2^DATAWIDTH-1) >> L. Tick period = TC(L)+1 cycles.
- State machine:
  - STOP: count held at 0. Goes to RUN when enable=1.
  - RUN: count increments each cycle. Goes to PAUSE when enable=0.
  - PAUSE: count, tickCount and pending are held. Goes back to RUN when enable=1 and resumes from the held count.
- clear (priority over enable): count=0, tickCount=0, state=STOP, T0 forced high. Level is unchanged. A pending load is kept.
- Tick event, in RUN only: when count==TC(level), count wraps to 0 and T0_OutLow is low in the next cycle only.
  - Output latency is 1 cycle.
  - Back-to-back ticks cannot occur, except at the minimum period of 2 cycles (LEVELS=DATAWIDTH, top level has TC=1).
- levelLoad:
  - The strobe stores a saturated value into the pending register: min(level_InBUS, LEVELS-1).
  - A later strobe before application overwrites it.
  - In STOP, the pending value is applied on the next cycle.
  - In RUN or PAUSE, it is applied only on a tick event. The level never changes mid-period.
  - Applying a load clears tickCount.
- Auto mode, on a tick event with autoMode=1 and no pending load:
  - tickCount increments.
  - When it reaches TICKS_PER_LEVEL, level increments (saturating at LEVELS-1) and tickCount clears.
  - At the maximum level, tickCount still wraps to 0 and the level stays put.
- Simultaneous events on the same tick:
  - A pending load beats auto-increment.
  - A levelLoad strobe arriving in the tick cycle is captured as pending and is not applied until the following tick.
  - clear beats everything.
- autoMode=0: tickCount is held, not cleared.
- level_OutBUS and maxLevel_Out change in the cycle after the tick edge, coincident with T0 low.
- An asynchronous reset mid-period aborts immediately; no tick is emitted.

Decomposition:
- Shared package or header holds:
  - state encodings STOP=2'd0, RUN=2'd1, PAUSE=2'd2;
  - the TC(L) function or localparam;
  - the level saturation function.
- One natural sub-module: cc_speedtick_tc_rom. It is combinational, maps level to TC, and is parametrised by DATAWIDTH/LEVELS.
- The counter, FSM and level logic stay in the top module.

Test Plan:
(Use DATAWIDTH=4, LEVELS=4, TICKS_PER_LEVEL=2 unless stated.)
1. Reset, then enable=1 at level 0 -> T0 low one cycle every 16 cycles; first low is 16 cycles after enable is sampled; level_OutBUS=0.
2. Load level 2 mid-period (count=5) -> current 16-cycle period completes; following periods are 4 cycles; level_OutBUS=2 coincident with the tick.
3. autoMode=1 from level 0 -> after 2 ticks level=1 (period 8), after 2 more level=2 (period 4), then level=3 (period 2) with maxLevel_Out=1; stays at 3 thereafter.
4. enable=0 at count=9 for 20 cycles, then enable=1 -> no tick while paused; next tick 7 cycles after resume.
5. levelLoad with level_InBUS=3 coincident with an auto-increment tick -> strobe ignored that tick; at the next tick level=3 and tickCount=0. Separately, with LEVELS=3, load level_InBUS=3 -> saturates to 2.
6. Assert reset at count=12, then clear at count=3 -> async reset: T0 stays high, level=0. Clear: count=0, state STOP, level kept.
